// File: rtl/rom_record_feeder.sv
// rom_record_feeder
//   Walks the ROM record inserter's shared address space and turns each returned
//   {ip_addr, url} pair into one record on a valid/ready stream. A ROM_LAT-deep
//   tag pipeline follows every issued address until its data returns. A small
//   FIFO absorbs downstream backpressure. Addresses are issued only while the
//   FIFO is guaranteed room for everything already in flight.
//
//   Optional feature: define FEEDER_LOOP_EN to add the 'loop' input. While it is
//   high at the end of a pass, the address wraps to 0 and the next pass follows
//   with no gap. done pulses only after the final pass.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a pass (honoured only in IDLE)
//   loop           (FEEDER_LOOP_EN only) continue with another pass
//   busy           high in RUN and DRAIN
//   done           one-cycle pulse on the handshake of the final record
//   rom_address    address to the inserter
//   rom_ip_addr    ip_addr data returned by the inserter
//   rom_url        url data returned by the inserter
//   out_valid      record available (FIFO not empty)
//   out_ready      downstream accepts
//   out_ip_addr    record ip address
//   out_url        record url
//   out_index      ROM address the record came from
//   out_last       record came from address NUM_RECORDS-1
//   fsm_state      current FSM state, for debug
//
// Handshake: a record transfers on any cycle where out_valid & out_ready. Once
// out_valid is high it stays high, and the payload stays unchanged, until that
// transfer happens.
module rom_record_feeder #(
  parameter int ADDR_W      = 12,
  parameter int NUM_RECORDS = 4096,
  parameter int ROM_LAT     = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef FEEDER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_ip_addr,
  input  logic [511:0]      rom_url,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ip_addr,
  output logic [511:0]      out_url,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RECORDS - 1);
  localparam logic [CNT_W:0]    DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  logic              loop_en;
  logic [ADDR_W-1:0] addr_q;
  logic              issue;
  logic              issue_last;
  logic              credit_ok;

  // tag pipeline: one stage per cycle of ROM latency
  logic [ROM_LAT-1:0] tag_valid;
  logic [ROM_LAT-1:0] tag_last;
  logic [ADDR_W-1:0]  tag_index [ROM_LAT];
  logic               push;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, pop;

  logic [31:0]       mem_ip    [FIFO_DEPTH];
  logic [511:0]      mem_url   [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_index [FIFO_DEPTH];
  logic              mem_last  [FIFO_DEPTH];

`ifdef FEEDER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign issue_last = (addr_q == LAST_ADDR);
  // An exiting tag still counts as in flight in the cycle it is pushed, so
  // this sum never lets the FIFO be over-committed.
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_SUM;

  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == DEPTH_CNT);
  assign pop   = !empty && out_ready;
  assign push  = tag_valid[ROM_LAT-1];

  // next-state / issue / done
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          issue = 1'b1;
          next_state = (issue_last && !loop_en) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (issue_last && !loop_en) next_state = DRAIN;
        end
      end
      DRAIN: begin
        // The final record is the only thing left once it reaches the head.
        if (pop && fifo_count == CNT_W'(1) && inflight == '0) begin
          done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // state register and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= next_state;
      // After the last address the counter returns to 0. This lets the next
      // start (or a looped pass) issue address 0 straight away.
      if (issue) addr_q <= issue_last ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_last  <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_index[i] <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_last[0]  <= issue_last;
      tag_index[0] <= addr_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
        tag_index[i] <= tag_index[i-1];
      end
    end
  end

  // occupancy counters and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      inflight   <= inflight + CNT_W'(issue) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage; entries are only read while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ip[wr_ptr]    <= rom_ip_addr;
      mem_url[wr_ptr]   <= rom_url;
      mem_index[wr_ptr] <= tag_index[ROM_LAT-1];
      mem_last[wr_ptr]  <= tag_last[ROM_LAT-1];
    end
  end

  // Payload is forced to zero while empty. Reset therefore leaves the
  // outputs at zero without resetting the storage array.
  assign out_valid   = !empty;
  assign out_ip_addr = empty ? '0 : mem_ip[rd_ptr];
  assign out_url     = empty ? '0 : mem_url[rd_ptr];
  assign out_index   = empty ? '0 : mem_index[rd_ptr];
  assign out_last    = empty ? 1'b0 : mem_last[rd_ptr];

  assign rom_address = addr_q;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  // credit rule: data must never return into a full FIFO
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
